muldiv_ctrl: RTL
================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: op_valid  in  1  EX-stage instruction valid, not flushed.
REQ-004 SHALL have ports: mult  in  2  {multu, mult} one-hot decode; div  in  2  {divu, div}; mfhl  in  2  {mfhi, mflo}; mthl  in  2  {mthi, mtlo}.
REQ-005 SHALL have ports: src_a  in  32  rs value; src_b  in  32  rt value.
REQ-006 SHALL have ports: cancel  in  1  exception flush, abort in-flight op.
REQ-007 SHALL have ports: busy  out  1  op in flight; stall  out  1  hold EX and earlier stages; done  out  1  one-cycle completion pulse.
REQ-008 SHALL have ports: hl_rdata  out  32  mfhi/mflo result; hi  out  32, lo  out  32  architectural HI/LO.

Function
REQ-009 SHALL implement states IDLE, MUL1, MUL2, DIV_RUN, DIV_FIX; busy = (state != IDLE).
REQ-010 In IDLE, op_valid & |mult SHALL latch operands, enter MUL1; MUL1->MUL2->IDLE, writing HI/LO = 64-bit product on the MUL2->IDLE edge (2 edges after issue edge).
REQ-011 mult SHALL treat operands as two's complement; multu SHALL treat them as unsigned.
REQ-012 In IDLE, op_valid & |div with src_b != 0 SHALL latch operand magnitudes and signs, clear the 6-bit counter, and enter DIV_RUN.
REQ-013 DIV_RUN SHALL perform one restoring quotient-bit step per cycle for exactly 32 cycles, then enter DIV_FIX.
REQ-014 DIV_FIX SHALL apply signs (quotient negated if signs differ, remainder takes dividend sign), write LO=quotient and HI=remainder, and return to IDLE (33 edges after issue).
REQ-015 Divide by zero SHALL go IDLE->DIV_FIX directly and write HI=src_a, LO=32'hFFFF_FFFF, 1 edge after issue.
REQ-016 div 32'h8000_0000 / 32'hFFFF_FFFF SHALL yield LO=32'h8000_0000, HI=0 with no trap.
REQ-017 done SHALL be high for exactly the one cycle after the HI/LO completion write.
REQ-018 mfhl SHALL drive hl_rdata combinationally from hi (mfhl[1]) or lo (mfhl[0]), else 0.
REQ-019 mthl in IDLE SHALL write src_a to HI (mthl[1]) or LO (mthl[0]) on the next edge.
REQ-020 stall SHALL = busy & op_valid & (|mult | |div | |mfhl | |mthl); the issuing op SHALL NOT itself stall.
REQ-021 New ops SHALL be accepted in the done cycle, since state is IDLE; mfhl in that cycle SHALL read the new values.
REQ-022 cancel SHALL force IDLE on the next edge with no HI/LO write and no done, overriding any completion or issue in that cycle.
REQ-023 Ops arriving while busy SHALL NOT be latched; they re-present while stall holds them.

Reset
REQ-024 rst SHALL asynchronously force state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0, stall=0.
REQ-025 rst mid-operation SHALL discard the in-flight result.

Configuration
REQ-026 With MULDIV_FAST_MUL_EN defined, multiply SHALL write HI/LO on the first edge after issue via MUL1->IDLE, and MUL2 is unreachable.
REQ-027 Without MULDIV_FAST_MUL_EN, multiply SHALL use the two-edge path of REQ-010.
REQ-028 Divide, mthl, mfhl, stall and done behaviour SHALL be identical in both builds.

Verification
REQ-029 mult src_a=32'hFFFF_FFFE, src_b=3 -> after 2 edges HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA, done pulse 1 cycle; multu same operands -> HI=2, LO=32'hFFFF_FFFA.
REQ-030 div src_a=-7, src_b=2 -> 33 edges later LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; busy high throughout; divu 100/7 -> LO=14, HI=2.
REQ-031 divu src_a=5, src_b=0 -> 1 edge later HI=5, LO=32'hFFFF_FFFF.
REQ-032 div issued, mflo presented at cycle 5 -> stall high until done cycle; hl_rdata equals new LO there.
REQ-033 div issued, cancel at cycle 10 -> IDLE next edge, HI/LO unchanged, no done; rst asserted at cycle 3 of mult -> outputs immediately zero.
REQ-034 Both MULDIV_FAST_MUL_EN builds: mult 6x7 -> LO=42 after 1 edge (defined) or 2 edges (undefined).

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX-stage request/response bundle for the HI/LO multiply-divide unit
//   master (pipeline side): op_valid, mult{multu,mult}, div{divu,div}, mfhl{mfhi,mflo},
//                           mthl{mthi,mtlo}, src_a (rs), src_b (rt), cancel
//   slave  (muldiv_ctrl):   busy, stall, done, hl_rdata, hi, lo
interface muldiv_ctrl_if;
    logic        op_valid;
    logic [1:0]  mult;
    logic [1:0]  div;
    logic [1:0]  mfhl;
    logic [1:0]  mthl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hl_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_valid, mult, div, mfhl, mthl, src_a, src_b, cancel,
        input  busy, stall, done, hl_rdata, hi, lo
    );

    modport slave (
        input  op_valid, mult, div, mfhl, mthl, src_a, src_b, cancel,
        output busy, stall, done, hl_rdata, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle multiply/divide controller owning architectural HI/LO
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : muldiv_ctrl_if.slave (operation decode/operands in; busy/stall/done/hl_rdata/hi/lo out)
//   MULDIV_FAST_MUL_EN : when defined, multiply completes one edge after issue (MUL1->IDLE)
module muldiv_ctrl (
    input  logic           clk,
    input  logic           rst,
    muldiv_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, MUL1, MUL2, DIV_RUN, DIV_FIX} state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    // Divide reuses a_q as the dividend/quotient shift register and b_q as divisor magnitude.
    logic [32:0] a_q, a_d, b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic        done_q, done_d;
`ifndef MULDIV_FAST_MUL_EN
    logic [63:0] prod_q, prod_d;
`endif

    logic [63:0] a_ext, b_ext, prod_full;
    logic [32:0] rem_sh, rem_diff;
    logic        sa, sb;
    logic [31:0] mag_a, mag_b;

    // Operands are held as 33-bit values (sign- or zero-extended at issue), so one
    // 64-bit two's complement product serves both mult and multu.
    assign a_ext     = {{31{a_q[32]}}, a_q};
    assign b_ext     = {{31{b_q[32]}}, b_q};
    assign prod_full = a_ext * b_ext;

    // Restoring step: shift next dividend bit into the partial remainder, subtract
    // if it fits. rem_diff[32] set means the trial subtraction went negative.
    assign rem_sh   = {rem_q, a_q[31]};
    assign rem_diff = rem_sh - {1'b0, b_q[31:0]};

    assign sa    = bus.div[0] & bus.src_a[31];
    assign sb    = bus.div[0] & bus.src_b[31];
    assign mag_a = sa ? (32'd0 - bus.src_a) : bus.src_a;
    assign mag_b = sb ? (32'd0 - bus.src_b) : bus.src_b;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        done_d  = 1'b0;
`ifndef MULDIV_FAST_MUL_EN
        prod_d  = prod_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    if (|bus.mult) begin
                        a_d     = {bus.mult[0] & bus.src_a[31], bus.src_a};
                        b_d     = {bus.mult[0] & bus.src_b[31], bus.src_b};
                        state_d = MUL1;
                    end else if (|bus.div) begin
                        if (bus.src_b == 32'd0) begin
                            // Divide by zero: preload the fixed result and let DIV_FIX write it unsigned.
                            a_d     = {1'b0, 32'hFFFF_FFFF};
                            rem_d   = bus.src_a;
                            q_neg_d = 1'b0;
                            r_neg_d = 1'b0;
                            state_d = DIV_FIX;
                        end else begin
                            a_d     = {1'b0, mag_a};
                            b_d     = {1'b0, mag_b};
                            rem_d   = 32'd0;
                            cnt_d   = 6'd0;
                            q_neg_d = sa ^ sb;
                            r_neg_d = sa;
                            state_d = DIV_RUN;
                        end
                    end else begin
                        if (bus.mthl[1]) hi_d = bus.src_a;
                        if (bus.mthl[0]) lo_d = bus.src_a;
                    end
                end
            end
            MUL1: begin
`ifdef MULDIV_FAST_MUL_EN
                hi_d    = prod_full[63:32];
                lo_d    = prod_full[31:0];
                done_d  = 1'b1;
                state_d = IDLE;
`else
                prod_d  = prod_full;
                state_d = MUL2;
`endif
            end
            MUL2: begin
`ifndef MULDIV_FAST_MUL_EN
                hi_d    = prod_q[63:32];
                lo_d    = prod_q[31:0];
                done_d  = 1'b1;
`endif
                state_d = IDLE;
            end
            DIV_RUN: begin
                if (!rem_diff[32]) begin
                    rem_d = rem_diff[31:0];
                    a_d   = {1'b0, a_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh[31:0];
                    a_d   = {1'b0, a_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = DIV_FIX;
            end
            DIV_FIX: begin
                lo_d    = q_neg_q ? (32'd0 - a_q[31:0]) : a_q[31:0];
                hi_d    = r_neg_q ? (32'd0 - rem_q) : rem_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over any completion, issue or mthi/mtlo write in the same cycle.
        if (bus.cancel) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 33'd0;
            b_q     <= 33'd0;
            rem_q   <= 32'd0;
            cnt_q   <= 6'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            done_q  <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
            prod_q  <= 64'd0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            done_q  <= done_d;
`ifndef MULDIV_FAST_MUL_EN
            prod_q  <= prod_d;
`endif
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.stall    = bus.busy & bus.op_valid &
                          (|bus.mult | |bus.div | |bus.mfhl | |bus.mthl);
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.hl_rdata = bus.mfhl[1] ? hi_q : (bus.mfhl[0] ? lo_q : 32'd0);
endmodule
